// File: rtl/alarm_pkg.sv
// Shared key codes, state encodings and BCD digit limits for the keypad
// time-entry controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTRY  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  typedef enum logic {
    TGT_TIME  = 1'b0,
    TGT_ALARM = 1'b1
  } target_t;

  localparam logic [3:0] KEY_SET_TIME  = 4'hA;
  localparam logic [3:0] KEY_SET_ALARM = 4'hB;
  localparam logic [3:0] KEY_CANCEL    = 4'hC;
  localparam logic [3:0] KEY_ENTER     = 4'hD;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

  localparam logic [3:0]  BCD_BLANK  = 4'hF;
  localparam logic [15:0] DISP_BLANK = {4{BCD_BLANK}};

  localparam logic [3:0] LIM_H1         = 4'd2;
  localparam logic [3:0] LIM_H0         = 4'd9;
  localparam logic [3:0] LIM_H0_AT_H1_2 = 4'd3;
  localparam logic [3:0] LIM_M1         = 4'd5;
  localparam logic [3:0] LIM_M0         = 4'd9;

  localparam logic [2:0] NUM_DIGITS = 3'd4;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/time_entry_ctrl_bcd_digit_check.sv
// Range check for one keyed BCD digit against its HH:MM position; the hour
// units limit tightens to 3 once the tens digit is 2.
module bcd_digit_check
  import alarm_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] dcnt,
  input  logic [3:0] h1,
  output logic       ok
);

  always_comb begin
    ok = 1'b0;
    case (dcnt)
      3'd0:    ok = (digit <= LIM_H1);
      3'd1:    ok = (h1 == LIM_H1) ? (digit <= LIM_H0_AT_H1_2) : (digit <= LIM_H0);
      3'd2:    ok = (digit <= LIM_M1);
      3'd3:    ok = (digit <= LIM_M0);
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad time-entry controller: collects HH:MM digits, range-checks them and
// hands the finished value to the clock or alarm with a one-cycle load strobe.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for SET_TIME / SET_ALARM; other keys ignored
// S_ENTRY  | collecting digits; C/timeout abort, D commits when 4 digits
// S_COMMIT | one cycle: publish new_time and pulse the target's strobe
module time_entry_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        one_sec,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] new_time,
  output logic        load_time,
  output logic        load_alarm,
  output logic        entry_active,
  output logic [15:0] entry_disp,
  output logic        key_error
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_SEC);

  state_t      state_q, state_nx;
  target_t     target_q, target_nx;
  logic [2:0]  dcnt_q, dcnt_nx;
  logic [7:0]  tmo_q, tmo_nx;
  logic [15:0] disp_q, disp_nx, disp_wr;
  logic [15:0] new_time_q, new_time_nx;
  logic        load_time_q, load_time_nx;
  logic        load_alarm_q, load_alarm_nx;
  logic        key_error_q, key_error_nx;
  logic        digit_ok;

  bcd_digit_check u_digit_check (
    .digit (key_code),
    .dcnt  (dcnt_q),
    .h1    (disp_q[15:12]),
    .ok    (digit_ok)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      target_q     <= TGT_TIME;
      dcnt_q       <= 3'd0;
      tmo_q        <= 8'd0;
      disp_q       <= DISP_BLANK;
      new_time_q   <= 16'h0000;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      key_error_q  <= 1'b0;
    end else begin
      state_q      <= state_nx;
      target_q     <= target_nx;
      dcnt_q       <= dcnt_nx;
      tmo_q        <= tmo_nx;
      disp_q       <= disp_nx;
      new_time_q   <= new_time_nx;
      load_time_q  <= load_time_nx;
      load_alarm_q <= load_alarm_nx;
      key_error_q  <= key_error_nx;
    end
  end

  // Buffer with the current key dropped into the next free nibble, MSB first.
  always_comb begin
    disp_wr = disp_q;
    case (dcnt_q)
      3'd0:    disp_wr[15:12] = key_code;
      3'd1:    disp_wr[11:8]  = key_code;
      3'd2:    disp_wr[7:4]   = key_code;
      3'd3:    disp_wr[3:0]   = key_code;
      default: disp_wr = disp_q;
    endcase
  end

  always_comb begin
    state_nx      = state_q;
    target_nx     = target_q;
    dcnt_nx       = dcnt_q;
    tmo_nx        = tmo_q;
    disp_nx       = disp_q;
    new_time_nx   = new_time_q;
    load_time_nx  = 1'b0;
    load_alarm_nx = 1'b0;
    key_error_nx  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_valid && (key_code == KEY_SET_TIME || key_code == KEY_SET_ALARM)) begin
          state_nx  = S_ENTRY;
          target_nx = (key_code == KEY_SET_ALARM) ? TGT_ALARM : TGT_TIME;
          dcnt_nx   = 3'd0;
          tmo_nx    = 8'd0;
          disp_nx   = DISP_BLANK;
        end
      end

      S_ENTRY: begin
        if (key_valid) begin
          // Any key press restarts the inactivity timer, even when a tick coincides.
          tmo_nx = 8'd0;
          if (is_digit(key_code)) begin
            if (digit_ok && dcnt_q < NUM_DIGITS) begin
              disp_nx = disp_wr;
              dcnt_nx = dcnt_q + 3'd1;
            end else begin
              key_error_nx = 1'b1;
            end
          end else begin
            case (key_code)
              KEY_SET_TIME, KEY_SET_ALARM: begin
                target_nx = (key_code == KEY_SET_ALARM) ? TGT_ALARM : TGT_TIME;
                dcnt_nx   = 3'd0;
                disp_nx   = DISP_BLANK;
              end
              KEY_CANCEL: begin
                state_nx = S_IDLE;
                dcnt_nx  = 3'd0;
                disp_nx  = DISP_BLANK;
              end
              KEY_ENTER: begin
                if (dcnt_q == NUM_DIGITS) state_nx = S_COMMIT;
                else                      key_error_nx = 1'b1;
              end
              default: ;
            endcase
          end
        end else if (tmo_q == TMO_LIMIT) begin
          state_nx = S_IDLE;
          dcnt_nx  = 3'd0;
          tmo_nx   = 8'd0;
          disp_nx  = DISP_BLANK;
        end else if (one_sec) begin
          tmo_nx = tmo_q + 8'd1;
        end
      end

      S_COMMIT: begin
        new_time_nx = disp_q;
        if (target_q == TGT_ALARM) load_alarm_nx = 1'b1;
        else                       load_time_nx  = 1'b1;
        disp_nx  = DISP_BLANK;
        dcnt_nx  = 3'd0;
        tmo_nx   = 8'd0;
        state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  assign new_time     = new_time_q;
  assign load_time    = load_time_q;
  assign load_alarm   = load_alarm_q;
  assign entry_active = (state_q == S_ENTRY);
  assign entry_disp   = disp_q;
  assign key_error    = key_error_q;

endmodule
